// File: rtl/counter_updown_checker.sv
// Scoreboard for the 8-bit up/down counter: tracks a cycle-accurate model of the
// counter from its control inputs and flags any divergence of count/carry.
module counter_updown_checker #(
    parameter int WIDTH       = 8,
    parameter int ERR_CNT_W   = 8,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mon_reset_n,
    input  logic                 mon_load,
    input  logic [WIDTH-1:0]     mon_data_in,
    input  logic                 mon_up_down,
    input  logic                 mon_count_en,
    input  logic [WIDTH-1:0]     mon_count,
    input  logic                 mon_carry,
    output logic                 armed,
    output logic                 mismatch,
    output logic                 err_sticky,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [WIDTH-1:0]     first_exp,
    output logic [WIDTH-1:0]     first_act
);

    typedef enum logic [1:0] {
        WAIT_RST = 2'd0,
        TRACK    = 2'd1,
        FAIL     = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0]     CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]     CNT_MAX = {WIDTH{1'b1}};
    localparam logic [ERR_CNT_W-1:0] ERR_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};

    state_t                 state, state_nxt;
    logic [WIDTH-1:0]       exp_count, exp_count_nxt;
    logic                   exp_carry, exp_carry_nxt;
    logic [WIDTH-1:0]       model_count;
    logic                   model_carry;
    logic                   compare_fail;
    logic                   mismatch_nxt;
    logic                   err_sticky_nxt;
    logic [ERR_CNT_W-1:0]   err_count_nxt;
    logic [WIDTH-1:0]       first_exp_nxt, first_act_nxt;

    // What a correct counter would show after this edge, given the sampled controls.
    always_comb begin
        model_count = exp_count;
        model_carry = 1'b0;
        if (!mon_reset_n) begin
            model_count = '0;
        end else if (mon_load) begin
            model_count = mon_data_in;
        end else if (mon_count_en) begin
            if (mon_up_down) begin
                model_count = exp_count + CNT_ONE;
                model_carry = (exp_count == CNT_MAX);
            end else begin
                model_count = exp_count - CNT_ONE;
                model_carry = (exp_count == '0);
            end
        end
    end

    assign compare_fail = (mon_count != exp_count) || (mon_carry != exp_carry);

    always_comb begin
        state_nxt      = state;
        exp_count_nxt  = exp_count;
        exp_carry_nxt  = exp_carry;
        mismatch_nxt   = 1'b0;
        err_sticky_nxt = err_sticky;
        err_count_nxt  = err_count;
        first_exp_nxt  = first_exp;
        first_act_nxt  = first_act;
        case (state)
            WAIT_RST: begin
                // The model free-runs but only becomes trustworthy once the
                // counter has been seen in reset; that edge forces it to zero.
                exp_count_nxt = model_count;
                exp_carry_nxt = model_carry;
                if (!mon_reset_n) begin
                    state_nxt = TRACK;
                end
            end
            TRACK: begin
                exp_count_nxt = model_count;
                exp_carry_nxt = model_carry;
                if (compare_fail) begin
                    mismatch_nxt   = 1'b1;
                    err_sticky_nxt = 1'b1;
                    if (err_count != ERR_MAX) begin
                        err_count_nxt = err_count + ERR_ONE;
                    end
                    if (!err_sticky) begin
                        first_exp_nxt = exp_count;
                        first_act_nxt = mon_count;
                    end
                    if (STOP_ON_ERR) begin
                        state_nxt = FAIL;
                    end
                end
            end
            FAIL: begin
                state_nxt = FAIL;
            end
            default: begin
                state_nxt = WAIT_RST;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= WAIT_RST;
            exp_count  <= '0;
            exp_carry  <= 1'b0;
            mismatch   <= 1'b0;
            err_sticky <= 1'b0;
            err_count  <= '0;
            first_exp  <= '0;
            first_act  <= '0;
        end else begin
            state      <= state_nxt;
            exp_count  <= exp_count_nxt;
            exp_carry  <= exp_carry_nxt;
            mismatch   <= mismatch_nxt;
            err_sticky <= err_sticky_nxt;
            err_count  <= err_count_nxt;
            first_exp  <= first_exp_nxt;
            first_act  <= first_act_nxt;
        end
    end

    assign armed = (state == TRACK) || (state == FAIL);

endmodule

// File: tb/tb_counter_updown_checker.sv
// Drives the checker as if it were watching a counter; a behavioural counter plus
// a model of the checker's reporting predict every output.
module tb_counter_updown_checker;

    localparam int W  = 8;
    localparam int EW = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         mon_reset_n, mon_load, mon_up_down, mon_count_en, mon_carry;
    logic [W-1:0] mon_data_in, mon_count;

    logic [1:0]    armed_v, mm_v, sticky_v;
    logic [EW-1:0] ec0, ec1;
    logic [W-1:0]  fe0, fe1, fa0, fa1;

    int checks = 0;
    int errors = 0;

    // reference counter (what a good counter shows) and checker expectations
    int       ref_cnt;
    bit       ref_cry;
    logic [W-1:0] fault_mask;
    bit       fault_cry;
    bit       m_armed[2], m_mm[2], m_sticky[2], m_frozen[2];
    int       m_ec[2], m_fe[2], m_fa[2];

    always #5 clk = ~clk;

    counter_updown_checker #(.WIDTH(W), .ERR_CNT_W(EW), .STOP_ON_ERR(1'b0)) dut (
        .clk(clk), .reset(reset), .mon_reset_n(mon_reset_n), .mon_load(mon_load),
        .mon_data_in(mon_data_in), .mon_up_down(mon_up_down), .mon_count_en(mon_count_en),
        .mon_count(mon_count), .mon_carry(mon_carry), .armed(armed_v[0]), .mismatch(mm_v[0]),
        .err_sticky(sticky_v[0]), .err_count(ec0), .first_exp(fe0), .first_act(fa0)
    );

    counter_updown_checker #(.WIDTH(W), .ERR_CNT_W(EW), .STOP_ON_ERR(1'b1)) dut_stop (
        .clk(clk), .reset(reset), .mon_reset_n(mon_reset_n), .mon_load(mon_load),
        .mon_data_in(mon_data_in), .mon_up_down(mon_up_down), .mon_count_en(mon_count_en),
        .mon_count(mon_count), .mon_carry(mon_carry), .armed(armed_v[1]), .mismatch(mm_v[1]),
        .err_sticky(sticky_v[1]), .err_count(ec1), .first_exp(fe1), .first_act(fa1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_armed[i] = 0; m_mm[i] = 0; m_sticky[i] = 0; m_frozen[i] = 0;
            m_ec[i] = 0; m_fe[i] = 0; m_fa[i] = 0;
        end
    endtask

    task automatic check_inst(input int i, input logic a, input logic m, input logic s,
                              input logic [EW-1:0] ec, input logic [W-1:0] fe,
                              input logic [W-1:0] fa);
        chk($sformatf("armed%0d", i), {31'd0, a}, {31'd0, m_armed[i]});
        chk($sformatf("mismatch%0d", i), {31'd0, m}, {31'd0, m_mm[i]});
        chk($sformatf("err_sticky%0d", i), {31'd0, s}, {31'd0, m_sticky[i]});
        chk($sformatf("err_count%0d", i), {24'd0, ec}, m_ec[i]);
        chk($sformatf("first_exp%0d", i), {24'd0, fe}, m_fe[i]);
        chk($sformatf("first_act%0d", i), {24'd0, fa}, m_fa[i]);
    endtask

    task automatic check_all();
        check_inst(0, armed_v[0], mm_v[0], sticky_v[0], ec0, fe0, fa0);
        check_inst(1, armed_v[1], mm_v[1], sticky_v[1], ec1, fe1, fa1);
    endtask

    // One clock: predict checker reaction to the values currently shown, advance the
    // reference counter, check outputs, then show the new counter value.
    task automatic step();
        logic [W-1:0] drv_cnt;
        logic         drv_cry;
        bit           f;
        drv_cnt = mon_count;
        drv_cry = mon_carry;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (!m_armed[i]) begin
                m_mm[i] = 0;
                if (!mon_reset_n) m_armed[i] = 1;
            end else if (m_frozen[i]) begin
                m_mm[i] = 0;
            end else begin
                f = (int'(drv_cnt) != ref_cnt) || (drv_cry != ref_cry);
                m_mm[i] = f;
                if (f) begin
                    if (!m_sticky[i]) begin
                        m_fe[i] = ref_cnt;
                        m_fa[i] = int'(drv_cnt);
                    end
                    m_sticky[i] = 1;
                    if (m_ec[i] < 255) m_ec[i]++;
                    if (i == 1) m_frozen[i] = 1;
                end
            end
        end
        if (!mon_reset_n) begin
            ref_cnt = 0; ref_cry = 0;
        end else if (mon_load) begin
            ref_cnt = int'(mon_data_in); ref_cry = 0;
        end else if (mon_count_en && mon_up_down) begin
            ref_cry = (ref_cnt == 255);
            ref_cnt = (ref_cnt + 1) % 256;
        end else if (mon_count_en) begin
            ref_cry = (ref_cnt == 0);
            ref_cnt = (ref_cnt + 255) % 256;
        end else begin
            ref_cry = 0;
        end
        #1;
        check_all();
        mon_count = W'(ref_cnt) ^ fault_mask;
        mon_carry = ref_cry ^ fault_cry;
    endtask

    initial begin
        mon_reset_n = 1; mon_load = 0; mon_data_in = '0; mon_up_down = 1; mon_count_en = 0;
        mon_count = '0; mon_carry = 0; fault_mask = '0; fault_cry = 0;
        ref_cnt = 0; ref_cry = 0;
        model_reset();
        #1 reset = 1;
        repeat (2) @(posedge clk);
        #1;
        check_all();
        reset = 0;

        // arm on observed counter reset, then count up through the wrap
        step();
        mon_reset_n = 0;
        step();
        step();
        chk("armed_after_rst", {31'd0, armed_v[0]}, 32'd1);
        mon_reset_n = 1; mon_count_en = 1; mon_up_down = 1;
        repeat (300) step();
        chk("up_err_count", {24'd0, ec0}, 32'd0);
        chk("up_err_sticky", {31'd0, sticky_v[0]}, 32'd0);

        // count down from 0: 255 (carry), 254, 253
        mon_reset_n = 0; mon_count_en = 0;
        step();
        mon_reset_n = 1; mon_count_en = 1; mon_up_down = 0;
        step(); mon_count = 8'hFF; mon_carry = 1;
        step(); chk("down_ff", {31'd0, mm_v[0]}, 32'd0); mon_count = 8'hFE; mon_carry = 0;
        step(); chk("down_fe", {31'd0, mm_v[0]}, 32'd0); mon_count = 8'hFD; mon_carry = 0;
        mon_count_en = 0;
        step(); chk("down_fd", {31'd0, mm_v[0]}, 32'd0);

        // load beats count_en, no carry
        mon_load = 1; mon_data_in = 8'hA5; mon_count_en = 1; mon_up_down = 1;
        step(); mon_count = 8'hA5; mon_carry = 0;
        mon_load = 0;
        step(); chk("load_a5", {31'd0, mm_v[0]}, 32'd0); mon_count = 8'hA6; mon_carry = 0;
        step(); chk("count_a6", {31'd0, mm_v[0]}, 32'd0);

        // first fault: expected 0F, shown 10
        mon_load = 1; mon_data_in = 8'h0F;
        step();
        mon_load = 0; mon_count_en = 0;
        mon_count = 8'h10;
        step();
        chk("fault_pulse", {31'd0, mm_v[0]}, 32'd1);
        chk("fault_count", {24'd0, ec0}, 32'd1);
        chk("fault_first_exp", {24'd0, fe0}, 32'h0F);
        chk("fault_first_act", {24'd0, fa0}, 32'h10);
        step();
        chk("fault_pulse_end", {31'd0, mm_v[0]}, 32'd0);

        // four more faults: stop-on-error instance stays frozen at one
        repeat (4) begin
            mon_count = mon_count ^ 8'h01;
            step();
        end
        chk("stop_err_count", {24'd0, ec1}, 32'd1);
        chk("stop_armed", {31'd0, armed_v[1]}, 32'd1);
        chk("run_err_count", {24'd0, ec0}, 32'd5);

        // 300 faults saturate the counter
        fault_mask = 8'h80;
        repeat (300) step();
        fault_mask = '0;
        step();
        chk("sat_err_count", {24'd0, ec0}, 32'd255);
        chk("sat_first_exp", {24'd0, fe0}, 32'h0F);

        // asynchronous checker reset mid-run
        #3 reset = 1;
        #1;
        model_reset();
        check_all();
        #1 reset = 0;
        fault_mask = 8'h33;
        repeat (5) step();
        chk("idle_no_compare", {24'd0, ec0}, 32'd0);
        fault_mask = '0; mon_reset_n = 0;
        step();
        mon_reset_n = 1;
        step();
        chk("rearmed", {31'd0, armed_v[0]}, 32'd1);

        // randomized traffic with occasional faults
        for (int n = 0; n < 400; n++) begin
            mon_reset_n  = ($urandom_range(31) != 0);
            mon_load     = ($urandom_range(7) == 0);
            mon_count_en = ($urandom_range(3) != 0);
            mon_up_down  = $urandom_range(1);
            mon_data_in  = W'($urandom_range(255));
            fault_mask   = '0;
            fault_cry    = 0;
            if ($urandom_range(24) == 0) begin
                if ($urandom_range(1) == 1) fault_mask = W'($urandom_range(255, 1));
                else                        fault_cry  = 1;
            end
            step();
        end
        fault_mask = '0; fault_cry = 0;
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
